sdram_frame_sched: RTL and testbench

//   Schedules the single SDRAM user port between the camera write path
//   (cam2fifo) and the VGA read path (fifo2vga).
//   - Issues one-row (512-word) burst requests to sdram_top.
//   - Generates per-frame row addresses and bank selects.
//   - Pulses FIFO clears on frame boundaries.

---
 rtl/sdram_frame_sched_if.sv | 45 ++++
 rtl/sdram_frame_sched.sv | 176 +++++++++++++++++
 tb/tb_sdram_frame_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_frame_sched_if.sv
// Bus bundle between sdram_frame_sched (master) and its FIFOs, bank_switch and sdram_top (slave).
// Stats ports exist only when SDRAM_SCHED_STATS_EN is defined.
interface sdram_frame_sched_if;
  logic        cmos_vsyn;
  logic        vga_vsyn;
  logic        wr_fifo_rdy;
  logic        rd_fifo_rdy;
  logic        rd_fifo_low;
  logic [1:0]  cam_bank;
  logic [1:0]  vga_bank;
  logic        wr_sdram_req;
  logic        wr_sdram_ack;
  logic [23:0] wr_sdram_add;
  logic        rd_sdram_req;
  logic        rd_sdram_ack;
  logic [23:0] rd_sdram_add;
  logic        clr_wr_fifo;
  logic        clr_rd_fifo;
  logic        wr_frame_done;
`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] wr_burst_cnt;
  logic [15:0] rd_burst_cnt;
  logic [15:0] rd_starve_cnt;
`endif

  modport master (
    input  cmos_vsyn, vga_vsyn, wr_fifo_rdy, rd_fifo_rdy, rd_fifo_low,
    input  cam_bank, vga_bank, wr_sdram_ack, rd_sdram_ack,
    output wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
`ifdef SDRAM_SCHED_STATS_EN
    output wr_burst_cnt, rd_burst_cnt, rd_starve_cnt,
`endif
    output clr_wr_fifo, clr_rd_fifo, wr_frame_done
  );

  modport slave (
    output cmos_vsyn, vga_vsyn, wr_fifo_rdy, rd_fifo_rdy, rd_fifo_low,
    output cam_bank, vga_bank, wr_sdram_ack, rd_sdram_ack,
    input  wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
`ifdef SDRAM_SCHED_STATS_EN
    input  wr_burst_cnt, rd_burst_cnt, rd_starve_cnt,
`endif
    input  clr_wr_fifo, clr_rd_fifo, wr_frame_done
  );
endinterface

// File: rtl/sdram_frame_sched.sv
// Arbitrates the single SDRAM user port between camera writes and VGA reads, one row per burst.
// Optional burst/starvation counters are enabled by defining SDRAM_SCHED_STATS_EN.
module sdram_frame_sched #(
  parameter int ROWS_PER_FRAME = 750,
  parameter int ROW_W          = 13
) (
  input logic               clk_133M,
  input logic               rst_133,
  sdram_frame_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

  localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS_PER_FRAME);

  state_t           state, state_n;
  logic [4:0]       sync_a, sync_b;
  logic             cmos_q, vga_q;
  logic [ROW_W-1:0] wr_row, rd_row;
  logic [1:0]       wr_bank, rd_bank;
  logic             pend_wr, pend_rd;
  logic             last_rd;
  logic             clr_wr, clr_rd;

  logic cmos_s, vga_s, wr_rdy_s, rd_rdy_s, rd_low_s;
  logic cam_sof, vga_sof, wr_elig, rd_elig, wr_ack_ok, rd_ack_ok;

  // Every async flag gets two flops; the vsyncs get a third for edge detection.
  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      sync_a <= '0;
      sync_b <= '0;
      cmos_q <= 1'b0;
      vga_q  <= 1'b0;
    end else begin
      sync_a <= {bus.rd_fifo_low, bus.rd_fifo_rdy, bus.wr_fifo_rdy, bus.vga_vsyn, bus.cmos_vsyn};
      sync_b <= sync_a;
      cmos_q <= sync_b[0];
      vga_q  <= sync_b[1];
    end
  end

  assign cmos_s   = sync_b[0];
  assign vga_s    = sync_b[1];
  assign wr_rdy_s = sync_b[2];
  assign rd_rdy_s = sync_b[3];
  assign rd_low_s = sync_b[4];

  assign cam_sof   = cmos_q & ~cmos_s;
  assign vga_sof   = vga_s & ~vga_q;
  assign wr_elig   = wr_rdy_s & (wr_row < ROW_LIMIT) & ~pend_wr;
  assign rd_elig   = rd_rdy_s & (rd_row < ROW_LIMIT) & ~pend_rd;
  assign wr_ack_ok = (state == WR_BUSY) & bus.wr_sdram_ack;
  assign rd_ack_ok = (state == RD_BUSY) & bus.rd_sdram_ack;

  always_ff @(posedge clk_133M) begin
    if (rst_133) state <= IDLE;
    else         state <= state_n;
  end

  // A nearly-empty read FIFO pre-empts round-robin; otherwise the side not served last wins.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (rd_elig & rd_low_s)     state_n = RD_BUSY;
        else if (wr_elig & rd_elig) state_n = last_rd ? WR_BUSY : RD_BUSY;
        else if (wr_elig)           state_n = WR_BUSY;
        else if (rd_elig)           state_n = RD_BUSY;
      end
      WR_BUSY: if (bus.wr_sdram_ack) state_n = IDLE;
      RD_BUSY: if (bus.rd_sdram_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A frame start during a burst is deferred so the burst address never changes under sdram_top.
  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      wr_row  <= '0;
      wr_bank <= 2'd0;
      pend_wr <= 1'b0;
      clr_wr  <= 1'b0;
    end else begin
      clr_wr <= 1'b0;
      if (wr_ack_ok) begin
        pend_wr <= 1'b0;
        if (pend_wr | cam_sof) begin
          wr_row  <= '0;
          wr_bank <= bus.cam_bank;
          clr_wr  <= 1'b1;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end else if (cam_sof) begin
        if (state == WR_BUSY) begin
          pend_wr <= 1'b1;
        end else begin
          wr_row  <= '0;
          wr_bank <= bus.cam_bank;
          clr_wr  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      rd_row  <= '0;
      rd_bank <= 2'd0;
      pend_rd <= 1'b0;
      clr_rd  <= 1'b0;
    end else begin
      clr_rd <= 1'b0;
      if (rd_ack_ok) begin
        pend_rd <= 1'b0;
        if (pend_rd | vga_sof) begin
          rd_row  <= '0;
          rd_bank <= bus.vga_bank;
          clr_rd  <= 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end else if (vga_sof) begin
        if (state == RD_BUSY) begin
          pend_rd <= 1'b1;
        end else begin
          rd_row  <= '0;
          rd_bank <= bus.vga_bank;
          clr_rd  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_133M) begin
    if (rst_133)        last_rd <= 1'b1;
    else if (wr_ack_ok) last_rd <= 1'b0;
    else if (rd_ack_ok) last_rd <= 1'b1;
  end

  assign bus.wr_sdram_req  = (state == WR_BUSY);
  assign bus.rd_sdram_req  = (state == RD_BUSY);
  assign bus.wr_sdram_add  = {wr_bank, wr_row, 9'd0};
  assign bus.rd_sdram_add  = {rd_bank, rd_row, 9'd0};
  assign bus.clr_wr_fifo   = clr_wr;
  assign bus.clr_rd_fifo   = clr_rd;
  assign bus.wr_frame_done = (wr_row == ROW_LIMIT);

`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] wr_cnt, rd_cnt, starve_cnt;

  // Per-frame counters: cleared by their own side's frame start, saturating otherwise.
  always_ff @(posedge clk_133M) begin
    if (rst_133) begin
      wr_cnt     <= 16'd0;
      rd_cnt     <= 16'd0;
      starve_cnt <= 16'd0;
    end else begin
      if (cam_sof)                             wr_cnt <= 16'd0;
      else if (wr_ack_ok && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (vga_sof)                             rd_cnt <= 16'd0;
      else if (rd_ack_ok && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (vga_sof)
        starve_cnt <= 16'd0;
      else if (rd_low_s && state == WR_BUSY && starve_cnt != 16'hFFFF)
        starve_cnt <= starve_cnt + 16'd1;
    end
  end

  assign bus.wr_burst_cnt  = wr_cnt;
  assign bus.rd_burst_cnt  = rd_cnt;
  assign bus.rd_starve_cnt = starve_cnt;
`endif

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Scoreboard bench for sdram_frame_sched: expected grants are queued as stimulus is applied
// and popped when a request rises; an auto-responder returns acks after a set delay.
module tb_sdram_frame_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_frame_sched_if bus ();

  sdram_frame_sched #(.ROWS_PER_FRAME(750), .ROW_W(13)) dut (
    .clk_133M (clk),
    .rst_133  (rst),
    .bus      (bus)
  );

  int          n_compared = 0;
  int          n_mismatch = 0;
  logic [24:0] exp_q[$];
  int          ack_delay  = 8;
  logic        stray_en   = 1'b0;
  int          clr_wr_count = 0;
  int          clr_rd_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr_rdy, input logic rd_rdy, input logic rd_low);
    bus.wr_fifo_rdy = wr_rdy;
    bus.rd_fifo_rdy = rd_rdy;
    bus.rd_fifo_low = rd_low;
  endtask

  task automatic push_exp(input logic is_wr, input logic [23:0] addr);
    exp_q.push_back({is_wr, addr});
  endtask

  task automatic wait_drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (k == budget) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!bus.wr_sdram_req && !bus.rd_sdram_req) break;
    end
    if (k == budget) checkOutput("idle_timeout", 32'({bus.wr_sdram_req, bus.rd_sdram_req}), 32'd0);
  endtask

  // Acks come ack_delay cycles after a request rises; a stray read ack can be injected into a write burst.
  initial begin
    bus.wr_sdram_ack = 1'b0;
    bus.rd_sdram_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && (bus.wr_sdram_req || bus.rd_sdram_req)) begin
        automatic logic is_wr = bus.wr_sdram_req;
        automatic int   dly   = ack_delay;
        automatic logic stray = stray_en;
        for (int k = 1; k < dly; k++) begin
          @(posedge clk); #1;
          bus.rd_sdram_ack = stray && is_wr && (k == 5);
        end
        bus.rd_sdram_ack = 1'b0;
        if (is_wr) bus.wr_sdram_ack = 1'b1;
        else       bus.rd_sdram_ack = 1'b1;
        @(posedge clk); #1;
        bus.wr_sdram_ack = 1'b0;
        bus.rd_sdram_ack = 1'b0;
      end
    end
  end

  // Scoreboard side: compare each new grant against the queue and check the address held to the ack.
  initial begin
    logic        prev_wr = 1'b0, prev_rd = 1'b0;
    logic [23:0] wr_cap = '0, rd_cap = '0;
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (bus.clr_wr_fifo) clr_wr_count++;
      if (bus.clr_rd_fifo) clr_rd_count++;
      if ((bus.wr_sdram_req && !prev_wr) || (bus.rd_sdram_req && !prev_rd)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_req", 32'({bus.wr_sdram_req, bus.rd_sdram_req}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("grant_side", 32'(bus.wr_sdram_req), 32'(e[24]));
          checkOutput("req_overlap", 32'(bus.wr_sdram_req & bus.rd_sdram_req), 32'd0);
          checkOutput("grant_addr", 32'(bus.wr_sdram_req ? bus.wr_sdram_add : bus.rd_sdram_add), 32'(e[23:0]));
        end
        wr_cap = bus.wr_sdram_add;
        rd_cap = bus.rd_sdram_add;
      end
      if (bus.wr_sdram_ack && bus.wr_sdram_req) checkOutput("wr_add_stable", 32'(bus.wr_sdram_add), 32'(wr_cap));
      if (bus.rd_sdram_ack && bus.rd_sdram_req) checkOutput("rd_add_stable", 32'(bus.rd_sdram_add), 32'(rd_cap));
      prev_wr = bus.wr_sdram_req;
      prev_rd = bus.rd_sdram_req;
    end
  end

  initial begin
    int c_wr, c_rd;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    bus.cmos_vsyn = 1'b0;
    bus.vga_vsyn  = 1'b0;
    bus.cam_bank  = 2'd0;
    bus.vga_bank  = 2'd0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_wr_req", 32'(bus.wr_sdram_req), 32'd0);
      checkOutput("rst_rd_req", 32'(bus.rd_sdram_req), 32'd0);
    end
    checkOutput("rst_wr_add", 32'(bus.wr_sdram_add), 32'd0);
    checkOutput("rst_rd_add", 32'(bus.rd_sdram_add), 32'd0);
    checkOutput("rst_frame_done", 32'(bus.wr_frame_done), 32'd0);
    checkOutput("rst_clr", 32'({bus.clr_wr_fifo, bus.clr_rd_fifo}), 32'd0);

    // Round-robin from reset: last served is RD, so WR goes first.
    for (int r = 0; r < 4; r++) begin
      push_exp(1'b1, 24'(r << 9));
      push_exp(1'b0, 24'(r << 9));
    end
    rst = 1'b0;
    wait_drain(200);
`ifdef SDRAM_SCHED_STATS_EN
    checkOutput("stat_wr_cnt", 32'(bus.wr_burst_cnt), 32'd4);
    checkOutput("stat_rd_cnt", 32'(bus.rd_burst_cnt), 32'd3);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_idle(50);

    // Urgent read overrides round-robin even though RD was served last.
    push_exp(1'b0, 24'(4 << 9));
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_drain(50);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_idle(50);

    // Write-only run up to row 37.
    for (int r = 4; r < 37; r++) push_exp(1'b1, 24'(r << 9));
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_drain(1000);
    ack_delay = 40;
    stray_en  = 1'b1;
    push_exp(1'b1, 24'(37 << 9));
    wait_drain(50);

    // Camera frame start while row 37 is in flight.
    c_wr = clr_wr_count;
    bus.cam_bank  = 2'd2;
    bus.cmos_vsyn = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.cmos_vsyn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_exp(1'b1, 24'h800000);
    checkOutput("held_req", 32'(bus.wr_sdram_req), 32'd1);
    checkOutput("held_add", 32'(bus.wr_sdram_add), 32'(37 << 9));
    checkOutput("stray_rd_req", 32'(bus.rd_sdram_req), 32'd0);
    checkOutput("stray_rd_add", 32'(bus.rd_sdram_add), 32'(5 << 9));
    checkOutput("no_early_clr", 32'(clr_wr_count - c_wr), 32'd0);
    ack_delay = 8;
    stray_en  = 1'b0;
    wait_drain(100);
    checkOutput("clr_wr_once", 32'(clr_wr_count - c_wr), 32'd1);
    checkOutput("frame_done_new", 32'(bus.wr_frame_done), 32'd0);

    // Finish the frame in bank 2, then confirm writes stop at the row limit.
    for (int r = 1; r < 750; r++) push_exp(1'b1, {2'b10, 13'(r), 9'd0});
    wait_drain(12000);
    wait_idle(30);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("frame_done", 32'(bus.wr_frame_done), 32'd1);
    checkOutput("no_req_at_limit", 32'(bus.wr_sdram_req), 32'd0);
    checkOutput("limit_add", 32'(bus.wr_sdram_add), 32'h800000 | 32'(750 << 9));

    // Both frame starts land on the same cycle; read side is idle and not ready.
    c_wr = clr_wr_count;
    c_rd = clr_rd_count;
    bus.cam_bank  = 2'd1;
    bus.vga_bank  = 2'd3;
    push_exp(1'b1, 24'h400000);
    bus.cmos_vsyn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.cmos_vsyn = 1'b0;
    bus.vga_vsyn  = 1'b1;
    wait_drain(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("frame_done_clr", 32'(bus.wr_frame_done), 32'd0);
    checkOutput("clr_wr_sof", 32'(clr_wr_count - c_wr), 32'd1);
    checkOutput("clr_rd_sof", 32'(clr_rd_count - c_rd), 32'd1);
    checkOutput("rd_reload_add", 32'(bus.rd_sdram_add), 32'hC00000);
    wait_idle(30);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
